series_controller: RTL and testbench

- Control FSM that drives the series-evaluation datapath (coefficient LUT, x² register, A/R registers, sign T-FF, term counter).
- Accepts a start request from the system and sequences load, multiply, compare and accumulate steps term by term.
- Ends on the datapath's stop (term below threshold y) or co (last LUT coefficient used), then reports done.
- Sits directly upstream of the datapath: produces every control input it has and consumes its stop and co outputs.

---
 rtl/series_controller_pkg.sv | 44 ++++
 rtl/series_controller_if.sv | 49 ++++
 rtl/series_controller.sv | 118 +++++++++++
 tb/tb_series_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/series_controller_pkg.sv
// -----------------------------------------------------------------------------
// series_controller_pkg
// Shared definitions for the series-evaluation controller: the FSM state
// encoding, the number of series terms handled by the datapath, and a packed
// bundle of the control strobes the controller drives into the datapath.
// -----------------------------------------------------------------------------
package series_controller_pkg;

   // The datapath term counter is 3 bits wide, so a run covers at most 8 terms.
   localparam int TERMS   = 8;
   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      MUL_LUT = 3'd2,
      CHECK   = 3'd3,
      ACC     = 3'd4,
      MUL_X2  = 3'd5,
      DONE    = 3'd6,
      HOLD    = 3'd7
   } state_t;

   // Every output of the controller, decoded from the current state.
   typedef struct packed {
      logic ready;
      logic done;
      logic count_en;
      logic iz_count;
      logic ld_x;
      logic ld_y;
      logic select_lut;
      logic select_x2;
      logic ld_a;
      logic iz_a;
      logic ld_r;
      logic iz_r;
      logic enable_tff;
      logic iz_tff;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

endpackage : series_controller_pkg

// File: rtl/series_controller_if.sv
// -----------------------------------------------------------------------------
// series_controller_if
// Bundles the handshake with the system (start/ready/done), the status fed back
// from the datapath (stop/co) and the datapath control strobes.
//   master : controller side  - drives ready, done and all control strobes,
//                                receives start, stop and co
//   slave  : system/datapath  - drives start, stop and co,
//                                receives ready, done and all control strobes
// -----------------------------------------------------------------------------
interface series_controller_if;

   // system handshake
   logic start;
   logic ready;
   logic done;

   // datapath status
   logic stop;   // current term in A is below threshold y
   logic co;     // term counter address = 7 (last coefficient)

   // datapath controls
   logic count_en;
   logic iz_count;
   logic LdX;
   logic LdY;
   logic select_lut;
   logic select_x2;
   logic LdA;
   logic iz_A;
   logic LdR;
   logic iz_R;
   logic enable_TFF;
   logic iz_TFF;

   modport master (
      input  start, stop, co,
      output ready, done,
      output count_en, iz_count, LdX, LdY, select_lut, select_x2,
      output LdA, iz_A, LdR, iz_R, enable_TFF, iz_TFF
   );

   modport slave (
      output start, stop, co,
      input  ready, done,
      input  count_en, iz_count, LdX, LdY, select_lut, select_x2,
      input  LdA, iz_A, LdR, iz_R, enable_TFF, iz_TFF
   );

endinterface : series_controller_if

// File: rtl/series_controller.sv
// -----------------------------------------------------------------------------
// series_controller
// Moore control FSM for the series-evaluation datapath. On a start request it
// initialises the datapath, then for each term multiplies by the LUT
// coefficient, checks the term against the threshold, accumulates it and
// multiplies by x^2 for the next term. The run ends when the datapath reports
// a term below threshold (stop, examined only in CHECK) or the last
// coefficient has been accumulated (co, examined only in ACC). done pulses for
// one cycle, then the FSM waits in HOLD until start is released.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, returns the FSM to IDLE
//   bus  - series_controller_if.master: start/stop/co in, ready/done and the
//          datapath control strobes out
//
// All outputs decode from the state register only.
// -----------------------------------------------------------------------------
module series_controller
   import series_controller_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   series_controller_if.master        bus
);

   state_t state_reg;
   state_t state_next;
   ctrl_t  ctrl;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = INIT;
         INIT:    state_next = MUL_LUT;
         MUL_LUT: state_next = CHECK;
         // A term below threshold is discarded, not accumulated.
         CHECK:   state_next = bus.stop ? DONE : ACC;
         // co reflects the address before this cycle's count_en, so it is
         // high while the last coefficient's term is being accumulated.
         ACC:     state_next = bus.co ? DONE : MUL_X2;
         MUL_X2:  state_next = MUL_LUT;
         DONE:    state_next = HOLD;
         // Require start to drop before a new run can be armed.
         HOLD:    if (!bus.start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode (state only)
   // ---------------------------------------------------------------------
   always_comb begin
      ctrl = CTRL_NONE;
      case (state_reg)
         IDLE: begin
            ctrl.ready = 1'b1;
         end
         INIT: begin
            ctrl.ld_x     = 1'b1;
            ctrl.ld_y     = 1'b1;
            ctrl.iz_a     = 1'b1;
            ctrl.iz_r     = 1'b1;
            ctrl.iz_count = 1'b1;
            ctrl.iz_tff   = 1'b1;
         end
         MUL_LUT: begin
            ctrl.select_lut = 1'b1;
            ctrl.ld_a       = 1'b1;
         end
         ACC: begin
            ctrl.ld_r       = 1'b1;
            ctrl.count_en   = 1'b1;
            ctrl.enable_tff = 1'b1;
         end
         MUL_X2: begin
            ctrl.select_x2 = 1'b1;
            ctrl.ld_a      = 1'b1;
         end
         DONE: begin
            ctrl.done = 1'b1;
         end
         default: begin
            ctrl = CTRL_NONE;
         end
      endcase
   end

   assign bus.ready      = ctrl.ready;
   assign bus.done       = ctrl.done;
   assign bus.count_en   = ctrl.count_en;
   assign bus.iz_count   = ctrl.iz_count;
   assign bus.LdX        = ctrl.ld_x;
   assign bus.LdY        = ctrl.ld_y;
   assign bus.select_lut = ctrl.select_lut;
   assign bus.select_x2  = ctrl.select_x2;
   assign bus.LdA        = ctrl.ld_a;
   assign bus.iz_A       = ctrl.iz_a;
   assign bus.LdR        = ctrl.ld_r;
   assign bus.iz_R       = ctrl.iz_r;
   assign bus.enable_TFF = ctrl.enable_tff;
   assign bus.iz_TFF     = ctrl.iz_tff;

endmodule : series_controller

// File: tb/tb_series_controller.sv
// -----------------------------------------------------------------------------
// tb_series_controller
// Self-checking bench for series_controller. A small model of the datapath
// term counter produces co. Each run pushes its expected completion cycle and
// strobe counts into a scoreboard queue; the entry is popped and compared when
// done is observed.
// -----------------------------------------------------------------------------
module tb_series_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;

   series_controller_if bus ();

   series_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model of the datapath 3-bit term counter; co is its address-7 flag.
   logic [2:0] addr_model = 3'd0;
   always @(posedge clk) begin
      if (rst)               addr_model <= 3'd0;
      else if (bus.iz_count) addr_model <= 3'd0;
      else if (bus.count_en) addr_model <= addr_model + 3'd1;
   end
   assign bus.co = (addr_model == 3'd7);

   // Output vector bit order:
   // ready done count_en iz_count LdX LdY sel_lut sel_x2 LdA iz_A LdR iz_R en_TFF iz_TFF
   localparam logic [13:0] V_IDLE    = 14'b10000000000000;
   localparam logic [13:0] V_INIT    = 14'b00011100010101;
   localparam logic [13:0] V_MUL_LUT = 14'b00000010100000;
   localparam logic [13:0] V_NONE    = 14'b00000000000000;
   localparam logic [13:0] V_ACC     = 14'b00100000001010;

   function automatic logic [13:0] outs();
      return {bus.ready, bus.done, bus.count_en, bus.iz_count, bus.LdX, bus.LdY,
              bus.select_lut, bus.select_x2, bus.LdA, bus.iz_A, bus.LdR,
              bus.iz_R, bus.enable_TFF, bus.iz_TFF};
   endfunction

   typedef struct {
      int done_cyc;
      int ldr;
      int lda;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.stop  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (outs() !== V_IDLE) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, outs(), V_IDLE);
         end
      end
      bus.start = 1'b0;
      rst       = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (outs() !== V_IDLE) begin
         n_fail++;
         $display("FAIL reset_release: got %b expected %b", outs(), V_IDLE);
      end
      $display("test_reset: outputs %b", outs());
   endtask

   // -------------------------------------------------------------------------
   // One complete run. stop_cyc: cycle in which stop is driven high (-1 none).
   // noise_cyc: cycle in which start is pulsed mid-run (-1 none).
   // hold_start: keep start high through DONE and HOLD.
   // -------------------------------------------------------------------------
   task automatic run_case(input string name, input int stop_cyc, input int noise_cyc,
                           input bit hold_start, input int exp_done,
                           input int exp_ldr, input int exp_lda);
      int   ldr_cnt = 0;
      int   cen_cnt = 0;
      int   lda_cnt = 0;
      int   done_cyc = -1;
      int   hold_cycles;
      exp_t e;
      exp_q.push_back('{done_cyc: exp_done, ldr: exp_ldr, lda: exp_lda});

      n_checks++;
      if (bus.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready_before_start: got %b expected 1", name, bus.ready);
      end

      bus.start = 1'b1;
      @(posedge clk); #1;           // edge sampling start = cycle 0
      if (!hold_start) bus.start = 1'b0;

      for (int cyc = 1; cyc <= 60; cyc++) begin
         ldr_cnt += int'(bus.LdR);
         cen_cnt += int'(bus.count_en);
         lda_cnt += int'(bus.LdA);
         if (cyc <= 4) begin
            logic [13:0] want;
            case (cyc)
               1:       want = V_INIT;
               2:       want = V_MUL_LUT;
               3:       want = V_NONE;
               default: want = V_ACC;
            endcase
            n_checks++;
            if (outs() !== want) begin
               n_fail++;
               $display("FAIL %s_latency cycle %0d: got %b expected %b", name, cyc, outs(), want);
            end
         end
         if (bus.select_lut === 1'b1 && bus.select_x2 === 1'b1) begin
            n_fail++;
            $display("FAIL %s_select_exclusive cycle %0d: got both 1 expected at most one", name, cyc);
         end
         if (bus.done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         bus.stop  = (cyc == stop_cyc);
         bus.start = hold_start | (cyc == noise_cyc);
         @(posedge clk); #1;
      end
      bus.stop = 1'b0;

      n_checks++;
      if (done_cyc < 0) begin
         n_fail++;
         $display("FAIL %s_timeout: got no done in 60 cycles expected done at %0d", name, exp_done);
         void'(exp_q.pop_front());
      end else begin
         e = exp_q.pop_front();
         if (done_cyc !== e.done_cyc) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_cyc, e.done_cyc);
         end
         n_checks++;
         if (ldr_cnt !== e.ldr || cen_cnt !== e.ldr) begin
            n_fail++;
            $display("FAIL %s_ldr_count: got LdR %0d count_en %0d expected %0d", name, ldr_cnt, cen_cnt, e.ldr);
         end
         n_checks++;
         if (lda_cnt !== e.lda) begin
            n_fail++;
            $display("FAIL %s_lda_count: got %0d expected %0d", name, lda_cnt, e.lda);
         end
      end

      // HOLD: no outputs, no second done, no restart while start stays high.
      hold_cycles = hold_start ? 4 : 1;
      for (int i = 0; i < hold_cycles; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (outs() !== V_NONE) begin
            n_fail++;
            $display("FAIL %s_hold cycle +%0d: got %b expected %b", name, i + 1, outs(), V_NONE);
         end
      end
      bus.start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (outs() !== V_IDLE) begin
         n_fail++;
         $display("FAIL %s_return_idle: got %b expected %b", name, outs(), V_IDLE);
      end
      $display("%s: done at cycle %0d, LdR %0d, count_en %0d, LdA %0d",
               name, done_cyc, ldr_cnt, cen_cnt, lda_cnt);
   endtask

   // -------------------------------------------------------------------------
   task automatic test_mid_run_reset();
      bus.start = 1'b1;
      @(posedge clk); #1;           // cycle 0 edge
      bus.start = 1'b0;
      for (int cyc = 1; cyc < 10; cyc++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;                   // asserted during cycle 10
      @(posedge clk); #1;
      n_checks++;
      if (outs() !== V_IDLE) begin
         n_fail++;
         $display("FAIL mid_run_reset: got %b expected %b", outs(), V_IDLE);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (outs() !== V_IDLE) begin
         n_fail++;
         $display("FAIL mid_run_reset_stays_idle: got %b expected %b", outs(), V_IDLE);
      end
      $display("test_mid_run_reset: outputs %b", outs());
   endtask

   // -------------------------------------------------------------------------
   initial begin
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      test_reset();
      run_case("test_full_run",     -1, -1, 1'b0, 33, 8, 15);
      run_case("test_early_stop",   11, -1, 1'b0, 12, 2, 5);
      run_case("test_simultaneous", 32, -1, 1'b0, 33, 8, 15);
      run_case("test_stop_in_acc",  12, -1, 1'b0, 33, 8, 15);
      run_case("test_held_start",    7, -1, 1'b1,  8, 1, 3);
      run_case("test_rearm_noise",  19,  5, 1'b0, 20, 4, 9);
      test_mid_run_reset();
      run_case("test_after_reset",  -1, -1, 1'b0, 33, 8, 15);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_series_controller
